// File: rtl/instr_encoder_pkg.sv
// Shared op list, RV32I opcode/funct constants and encode helpers for instr_encoder.
// imm_in_range exists only when IMM_RANGE_CHECK_EN is defined.
package instr_encoder_pkg;

  typedef enum logic [4:0] {
    OP_NOP, OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA,
    OP_OR, OP_AND, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_BLT, OP_BLTU,
    OP_JALR, OP_JAL, OP_AUIPC
  } op_e;

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_DRAIN} state_e;

  typedef enum logic [2:0] {FMT_NONE, FMT_R, FMT_I, FMT_S, FMT_B, FMT_J, FMT_U} fmt_e;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_I_ALU  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;
  localparam logic [2:0] F3_W    = 3'b010;
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BLTU = 3'b110;

  localparam logic [6:0]  F7_BASE  = 7'b0000000;
  localparam logic [6:0]  F7_ALT   = 7'b0100000;
  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  function automatic fmt_e op_fmt(input logic [4:0] op);
    fmt_e f;
    f = FMT_NONE;
    case (op)
      OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU,
      OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND:   f = FMT_R;
      OP_ADDI, OP_LW, OP_JALR:                 f = FMT_I;
      OP_SW:                                   f = FMT_S;
      OP_BEQ, OP_BNE, OP_BLT, OP_BLTU:         f = FMT_B;
      OP_JAL:                                  f = FMT_J;
      OP_AUIPC:                                f = FMT_U;
      default:                                 f = FMT_NONE;
    endcase
    return f;
  endfunction

  // Unknown op codes and nop both fall through to the canonical nop word.
  function automatic logic [31:0] encode(input logic [4:0] op, input logic [4:0] rd,
                                         input logic [4:0] rs1, input logic [4:0] rs2,
                                         input logic [31:0] imm);
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] w;
    opc = OPC_R;
    f3  = F3_ADD;
    f7  = F7_BASE;
    case (op)
      OP_SUB:   f7 = F7_ALT;
      OP_SLL:   f3 = F3_SLL;
      OP_SLT:   f3 = F3_SLT;
      OP_SLTU:  f3 = F3_SLTU;
      OP_XOR:   f3 = F3_XOR;
      OP_SRL:   f3 = F3_SR;
      OP_SRA:   begin f3 = F3_SR; f7 = F7_ALT; end
      OP_OR:    f3 = F3_OR;
      OP_AND:   f3 = F3_AND;
      OP_ADDI:  opc = OPC_I_ALU;
      OP_LW:    begin opc = OPC_LOAD;   f3 = F3_W;    end
      OP_SW:    begin opc = OPC_STORE;  f3 = F3_W;    end
      OP_BEQ:   begin opc = OPC_BRANCH; f3 = F3_BEQ;  end
      OP_BNE:   begin opc = OPC_BRANCH; f3 = F3_BNE;  end
      OP_BLT:   begin opc = OPC_BRANCH; f3 = F3_BLT;  end
      OP_BLTU:  begin opc = OPC_BRANCH; f3 = F3_BLTU; end
      OP_JALR:  opc = OPC_JALR;
      OP_JAL:   opc = OPC_JAL;
      OP_AUIPC: opc = OPC_AUIPC;
      default:  opc = OPC_R;
    endcase
    case (op_fmt(op))
      FMT_R:   w = {f7, rs2, rs1, f3, rd, opc};
      FMT_I:   w = {imm[11:0], rs1, f3, rd, opc};
      FMT_S:   w = {imm[11:5], rs2, rs1, f3, imm[4:0], opc};
      FMT_B:   w = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], opc};
      FMT_J:   w = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opc};
      FMT_U:   w = {imm[31:12], rd, opc};
      default: w = NOP_WORD;
    endcase
    return w;
  endfunction

`ifdef IMM_RANGE_CHECK_EN
  function automatic logic imm_in_range(input fmt_e fmt, input logic [31:0] imm);
    logic ok;
    case (fmt)
      FMT_I, FMT_S: ok = (imm[31:11] == {21{imm[11]}});
      FMT_B:        ok = (imm[31:12] == {20{imm[12]}}) && !imm[0];
      FMT_J:        ok = (imm[31:20] == {12{imm[20]}}) && !imm[0];
      FMT_U:        ok = (imm[11:0] == 12'h000);
      default:      ok = 1'b1;
    endcase
    return ok;
  endfunction
`endif

endpackage

// File: rtl/enc_fifo.sv
// Synchronous FIFO with occupancy count; DEPTH need not be a power of two.
// Push while full is legal only together with a pop.
module enc_fifo #(
  parameter int DEPTH = 3,
  parameter int W     = 32,
  localparam int CW   = $clog2(DEPTH + 1),
  localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [W-1:0]  wdata,
  input  logic          pop,
  output logic [W-1:0]  rdata,
  output logic          empty,
  output logic          full,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));
  assign rdata = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_next(wr_ptr);
      if (pop)  rd_ptr <= ptr_next(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/instr_encoder.sv
// Encodes request beats to RV32I words and streams them to instruction memory.
// Optional immediate range checking is enabled by defining IMM_RANGE_CHECK_EN.
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_start,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_last,
  input  logic [4:0]  in_op,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [31:0] in_imm,
  output logic        imem_we,
  input  logic        imem_ready,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output state_e      state_dbg
);

  // Handshakes: a beat moves on in_valid && in_ready, a word on imem_we && imem_ready;
  // the producer holds its payload stable until the transfer cycle.
  localparam int CW  = $clog2(FIFO_DEPTH + 1);
  localparam int FCW = $clog2(FIFO_DEPTH);

  state_e          state, state_n;
  logic            accept, beat_ok, drain_exit;
  logic            enc_valid;
  logic [31:0]     enc_word;
  logic            fifo_push, fifo_pop, fifo_empty, fifo_full;
  logic [31:0]     fifo_rdata;
  logic [FCW-1:0]  fifo_count;
  logic [CW-1:0]   occ;

  // The encode register counts toward occupancy, so the FIFO holds one word fewer.
  assign occ        = CW'(fifo_count) + CW'(enc_valid);
  assign in_ready   = (state == ST_LOAD) && (occ < CW'(FIFO_DEPTH));
  assign accept     = in_valid && in_ready;
  assign fifo_pop   = !fifo_empty && imem_ready;
  assign fifo_push  = enc_valid && (!fifo_full || fifo_pop);
  assign drain_exit = (state == ST_DRAIN) && (occ == '0);

  assign imem_we    = !fifo_empty;
  assign imem_wdata = fifo_empty ? 32'h0 : fifo_rdata;
  assign busy       = (state != ST_IDLE);
  assign state_dbg  = state;

`ifdef IMM_RANGE_CHECK_EN
  assign beat_ok = imm_in_range(op_fmt(in_op), in_imm);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err <= 1'b0;
    else        err <= accept && !beat_ok;
  end
`else
  assign beat_ok = 1'b1;
  assign err     = 1'b0;
`endif

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE:  if (load_start) state_n = ST_LOAD;
      ST_LOAD:  if (accept && in_last) state_n = ST_DRAIN;
      ST_DRAIN: if (drain_exit) state_n = ST_IDLE;
      default:  state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      done  <= drain_exit;
    end
  end

  // A rejected beat still completes the handshake but never reaches the FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enc_valid <= 1'b0;
      enc_word  <= 32'h0;
    end else if (accept && beat_ok) begin
      enc_valid <= 1'b1;
      enc_word  <= encode(in_op, in_rd, in_rs1, in_rs2, in_imm);
    end else if (fifo_push) begin
      enc_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                            imem_addr <= BASE_ADDR;
    else if (state == ST_IDLE && load_start) imem_addr <= BASE_ADDR;
    else if (fifo_pop)                     imem_addr <= imem_addr + 32'd4;
  end

  enc_fifo #(
    .DEPTH (FIFO_DEPTH - 1),
    .W     (32)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .wdata (enc_word),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .empty (fifo_empty),
    .full  (fifo_full),
    .count (fifo_count)
  );

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: a BASE_ADDR=0 instance plus a wrap-around instance.
// Expected words are hand-encoded RV32I values.
module tb_instr_encoder;
  import instr_encoder_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load_start = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic [4:0]  in_op = '0, in_rd = '0, in_rs1 = '0, in_rs2 = '0;
  logic [31:0] in_imm = '0;
  logic        imem_ready = 1'b0;

  logic        in_ready, imem_we, busy, done, err;
  logic [31:0] imem_addr, imem_wdata;
  state_e      state_dbg;
  logic        w_in_ready, w_imem_we, w_busy, w_done, w_err;
  logic [31:0] w_imem_addr, w_imem_wdata;
  state_e      w_state_dbg;

  int n_checks = 0;
  int n_fail   = 0;

  // clock / reset
  always #5 clk = ~clk;

  instr_encoder #(.BASE_ADDR(32'h0000_0000), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .load_start(load_start), .in_valid(in_valid),
    .in_ready(in_ready), .in_last(in_last), .in_op(in_op), .in_rd(in_rd),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .imem_we(imem_we),
    .imem_ready(imem_ready), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .busy(busy), .done(done), .err(err), .state_dbg(state_dbg)
  );

  instr_encoder #(.BASE_ADDR(32'hFFFF_FFF8), .FIFO_DEPTH(4)) dut_w (
    .clk(clk), .rst_n(rst_n), .load_start(load_start), .in_valid(in_valid),
    .in_ready(w_in_ready), .in_last(in_last), .in_op(in_op), .in_rd(in_rd),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .imem_we(w_imem_we),
    .imem_ready(imem_ready), .imem_addr(w_imem_addr), .imem_wdata(w_imem_wdata),
    .busy(w_busy), .done(w_done), .err(w_err), .state_dbg(w_state_dbg)
  );

  // scoreboard capture
  logic [31:0] wr_addr_q[$], wr_data_q[$], w_addr_q[$], w_data_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] exp_addr_q[$];
  int cyc = 0, acc_cnt = 0, first_acc_cyc = 0, first_wr_cyc = 0;
  int done_cnt = 0, w_done_cnt = 0, err_cnt = 0;

  always @(posedge clk) begin
    if (in_valid && in_ready) begin
      if (acc_cnt == 0) first_acc_cyc = cyc;
      acc_cnt++;
    end
    if (imem_we && imem_ready) begin
      if (wr_data_q.size() == 0) first_wr_cyc = cyc;
      wr_addr_q.push_back(imem_addr);
      wr_data_q.push_back(imem_wdata);
    end
    if (w_imem_we && imem_ready) begin
      w_addr_q.push_back(w_imem_addr);
      w_data_q.push_back(w_imem_wdata);
    end
    if (done)   done_cnt++;
    if (w_done) w_done_cnt++;
    if (err)    err_cnt++;
    cyc++;
  end

  // driver tasks
  logic [4:0]  b_op[8], b_rd[8], b_rs1[8], b_rs2[8];
  logic [31:0] b_imm[8];

  task automatic set_beat(input int i, input logic [4:0] op, input logic [4:0] rd,
                          input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm);
    b_op[i] = op; b_rd[i] = rd; b_rs1[i] = rs1; b_rs2[i] = rs2; b_imm[i] = imm;
  endtask

  task automatic clear_mon();
    wr_addr_q.delete(); wr_data_q.delete(); w_addr_q.delete(); w_data_q.delete();
    exp_q.delete(); exp_addr_q.delete();
    acc_cnt = 0; done_cnt = 0; w_done_cnt = 0; err_cnt = 0;
  endtask

  task automatic pulse_load();
    @(negedge clk); load_start = 1'b1;
    @(negedge clk); load_start = 1'b0;
  endtask

  // Offers beats start..n-1 for at most max_cyc cycles; sent = index reached.
  task automatic drive_beats(input int start, input int n, input int max_cyc, output int sent);
    logic acc;
    sent = start;
    for (int c = 0; c < max_cyc && sent < n; c++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_op = b_op[sent]; in_rd = b_rd[sent]; in_rs1 = b_rs1[sent];
      in_rs2 = b_rs2[sent]; in_imm = b_imm[sent];
      in_last = (sent == n - 1);
      acc = in_ready;
      @(posedge clk);
      if (acc) sent++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit seen);
    seen = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (done_cnt > 0 && w_done_cnt > 0) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  // tests
  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
    n_checks++; if (imem_we !== 1'b0) begin n_fail++; $display("FAIL reset_imem_we: got %b expected 0", imem_we); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (done !== 1'b0 || err !== 1'b0) begin n_fail++; $display("FAIL reset_done_err: got %b%b expected 00", done, err); end
    n_checks++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_addr: got %h expected 00000000", imem_addr); end
    n_checks++; if (imem_wdata !== 32'h0) begin n_fail++; $display("FAIL reset_wdata: got %h expected 00000000", imem_wdata); end
    n_checks++; if (state_dbg !== ST_IDLE || w_state_dbg !== ST_IDLE) begin n_fail++; $display("FAIL reset_state: got %0d/%0d expected 0", state_dbg, w_state_dbg); end
    n_checks++; if (w_imem_addr !== 32'hFFFF_FFF8) begin n_fail++; $display("FAIL reset_base_addr: got %h expected fffffff8", w_imem_addr); end
    n_checks++; if (w_busy !== 1'b0 || w_in_ready !== 1'b0 || w_err !== 1'b0) begin n_fail++; $display("FAIL reset_w_outputs: got %b%b%b expected 000", w_busy, w_in_ready, w_err); end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_add();
    int sent; bit seen;
    clear_mon(); imem_ready = 1'b1;
    exp_q.push_back(32'h002081B3); exp_addr_q.push_back(32'h0);
    pulse_load();
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL load_busy: got %b expected 1", busy); end
    set_beat(0, OP_ADD, 5'd3, 5'd1, 5'd2, 32'h0);
    drive_beats(0, 1, 20, sent);
    wait_done(50, seen);
    n_checks++; if (!seen) begin n_fail++; $display("FAIL add_done: got %b expected 1", seen); end
    n_checks++; if (wr_data_q.size() != 1) begin n_fail++; $display("FAIL add_count: got %0d expected 1", wr_data_q.size()); end
    for (int i = 0; i < exp_q.size() && i < wr_data_q.size(); i++) begin
      n_checks++; if (wr_data_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL add_data: got %h expected %h", wr_data_q[i], exp_q[i]); end
      n_checks++; if (wr_addr_q[i] !== exp_addr_q[i]) begin n_fail++; $display("FAIL add_addr: got %h expected %h", wr_addr_q[i], exp_addr_q[i]); end
    end
    n_checks++; if (first_wr_cyc - first_acc_cyc != 2) begin n_fail++; $display("FAIL add_latency: got %0d expected 2", first_wr_cyc - first_acc_cyc); end
    n_checks++; if (busy !== 1'b0 || done_cnt != 1) begin n_fail++; $display("FAIL add_idle: got busy=%b done=%0d expected busy=0 done=1", busy, done_cnt); end
  endtask

  task automatic test_sequence();
    int sent; bit seen;
    clear_mon(); imem_ready = 1'b1;
    set_beat(0, OP_SW,  5'd0, 5'd2, 5'd5, 32'd8);
    set_beat(1, OP_BEQ, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFFC);
    set_beat(2, OP_JAL, 5'd1, 5'd0, 5'd0, 32'd8);
    exp_q = '{32'h00512423, 32'hFE208EE3, 32'h008000EF};
    exp_addr_q = '{32'h0, 32'h4, 32'h8};
    pulse_load();
    drive_beats(0, 3, 30, sent);
    wait_done(50, seen);
    n_checks++; if (!seen || wr_data_q.size() != 3) begin n_fail++; $display("FAIL seq_count: got %0d done=%b expected 3 done=1", wr_data_q.size(), seen); end
    for (int i = 0; i < exp_q.size() && i < wr_data_q.size(); i++) begin
      n_checks++; if (wr_data_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL seq_data[%0d]: got %h expected %h", i, wr_data_q[i], exp_q[i]); end
      n_checks++; if (wr_addr_q[i] !== exp_addr_q[i]) begin n_fail++; $display("FAIL seq_addr[%0d]: got %h expected %h", i, wr_addr_q[i], exp_addr_q[i]); end
    end
  endtask

  task automatic test_ops();
    int sent; bit seen;
    clear_mon(); imem_ready = 1'b1;
    set_beat(0, OP_SUB,   5'd5, 5'd6, 5'd7, 32'h0);
    set_beat(1, OP_SRA,   5'd1, 5'd2, 5'd3, 32'h0);
    set_beat(2, OP_AUIPC, 5'd4, 5'd0, 5'd0, 32'h1234_5000);
    set_beat(3, OP_NOP,   5'd9, 5'd9, 5'd9, 32'h5);
    set_beat(4, OP_LW,    5'd2, 5'd3, 5'd0, 32'hFFFF_FFF8);
    exp_q = '{32'h407302B3, 32'h403150B3, 32'h12345217, 32'h00000013, 32'hFF81A103};
    pulse_load();
    drive_beats(0, 5, 40, sent);
    wait_done(50, seen);
    n_checks++; if (!seen || wr_data_q.size() != 5) begin n_fail++; $display("FAIL ops_count: got %0d done=%b expected 5 done=1", wr_data_q.size(), seen); end
    for (int i = 0; i < exp_q.size() && i < wr_data_q.size(); i++) begin
      n_checks++; if (wr_data_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL ops_data[%0d]: got %h expected %h", i, wr_data_q[i], exp_q[i]); end
      n_checks++; if (wr_addr_q[i] !== 32'(i * 4)) begin n_fail++; $display("FAIL ops_addr[%0d]: got %h expected %h", i, wr_addr_q[i], 32'(i * 4)); end
    end
  endtask

  task automatic test_backpressure();
    int sent; bit seen;
    clear_mon(); imem_ready = 1'b0;
    for (int i = 0; i < 6; i++) set_beat(i, OP_ADDI, 5'(i + 1), 5'd0, 5'd0, 32'(i + 1));
    exp_q = '{32'h00100093, 32'h00200113, 32'h00300193, 32'h00400213, 32'h00500293, 32'h00600313};
    pulse_load();
    drive_beats(0, 6, 10, sent);
    n_checks++; if (sent != 4 || acc_cnt != 4) begin n_fail++; $display("FAIL bp_accepted: got %0d/%0d expected 4", sent, acc_cnt); end
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready: got %b expected 0", in_ready); end
    n_checks++; if (wr_data_q.size() != 0) begin n_fail++; $display("FAIL bp_early_write: got %0d expected 0", wr_data_q.size()); end
    imem_ready = 1'b1;
    drive_beats(sent, 6, 40, sent);
    wait_done(60, seen);
    n_checks++; if (!seen || sent != 6 || wr_data_q.size() != 6) begin n_fail++; $display("FAIL bp_count: got %0d sent=%0d expected 6", wr_data_q.size(), sent); end
    for (int i = 0; i < exp_q.size() && i < wr_data_q.size(); i++) begin
      n_checks++; if (wr_data_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL bp_data[%0d]: got %h expected %h", i, wr_data_q[i], exp_q[i]); end
      n_checks++; if (wr_addr_q[i] !== 32'(i * 4)) begin n_fail++; $display("FAIL bp_addr[%0d]: got %h expected %h", i, wr_addr_q[i], 32'(i * 4)); end
    end
  endtask

  task automatic test_imm_range();
    int sent; bit seen;
    clear_mon(); imem_ready = 1'b1;
    set_beat(0, OP_ADDI, 5'd1, 5'd0, 5'd0, 32'd2048);
    pulse_load();
    drive_beats(0, 1, 20, sent);
    wait_done(50, seen);
    n_checks++; if (!seen) begin n_fail++; $display("FAIL imm_done: got %b expected 1", seen); end
`ifdef IMM_RANGE_CHECK_EN
    n_checks++; if (err_cnt != 1) begin n_fail++; $display("FAIL imm_err: got %0d expected 1", err_cnt); end
    n_checks++; if (wr_data_q.size() != 0) begin n_fail++; $display("FAIL imm_nowrite: got %0d expected 0", wr_data_q.size()); end
`else
    n_checks++; if (err_cnt != 0) begin n_fail++; $display("FAIL imm_err: got %0d expected 0", err_cnt); end
    n_checks++; if (wr_data_q.size() != 1) begin n_fail++; $display("FAIL imm_count: got %0d expected 1", wr_data_q.size()); end
    else if (wr_data_q[0] !== 32'h80000093 || wr_addr_q[0] !== 32'h0) begin
      n_fail++; $display("FAIL imm_data: got %h@%h expected 80000093@00000000", wr_data_q[0], wr_addr_q[0]);
    end
`endif
  endtask

  task automatic test_reset_midload();
    int sent;
    clear_mon(); imem_ready = 1'b0;
    for (int i = 0; i < 3; i++) set_beat(i, OP_ADD, 5'(i + 1), 5'd1, 5'd2, 32'h0);
    pulse_load();
    drive_beats(0, 3, 10, sent);
    repeat (2) @(negedge clk);
    n_checks++; if (sent != 3 || imem_we !== 1'b1) begin n_fail++; $display("FAIL rst_pre: got sent=%0d we=%b expected 3/1", sent, imem_we); end
    rst_n = 1'b0;
    #1;
    n_checks++; if (imem_we !== 1'b0) begin n_fail++; $display("FAIL rst_we: got %b expected 0", imem_we); end
    n_checks++; if (state_dbg !== ST_IDLE || busy !== 1'b0) begin n_fail++; $display("FAIL rst_state: got %0d busy=%b expected 0/0", state_dbg, busy); end
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready: got %b expected 0", in_ready); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1; imem_ready = 1'b1;
    repeat (10) @(negedge clk);
    n_checks++; if (wr_data_q.size() != 0 || w_data_q.size() != 0) begin n_fail++; $display("FAIL rst_nowrite: got %0d/%0d expected 0", wr_data_q.size(), w_data_q.size()); end
    n_checks++; if (imem_we !== 1'b0) begin n_fail++; $display("FAIL rst_we_after: got %b expected 0", imem_we); end
  endtask

  task automatic test_addr_wrap();
    int sent; bit seen;
    clear_mon(); imem_ready = 1'b1;
    for (int i = 0; i < 3; i++) set_beat(i, OP_NOP, 5'd0, 5'd0, 5'd0, 32'h0);
    exp_addr_q = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};
    pulse_load();
    drive_beats(0, 3, 30, sent);
    wait_done(50, seen);
    n_checks++; if (!seen || w_addr_q.size() != 3) begin n_fail++; $display("FAIL wrap_count: got %0d done=%b expected 3 done=1", w_addr_q.size(), seen); end
    for (int i = 0; i < exp_addr_q.size() && i < w_addr_q.size(); i++) begin
      n_checks++; if (w_addr_q[i] !== exp_addr_q[i]) begin n_fail++; $display("FAIL wrap_addr[%0d]: got %h expected %h", i, w_addr_q[i], exp_addr_q[i]); end
      n_checks++; if (w_data_q[i] !== 32'h00000013) begin n_fail++; $display("FAIL wrap_data[%0d]: got %h expected 00000013", i, w_data_q[i]); end
    end
  endtask

  // final report
  initial begin
    test_reset();
    test_single_add();
    test_sequence();
    test_ops();
    test_backpressure();
    test_imm_range();
    test_reset_midload();
    test_addr_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
